mdu_iterative: RTL and testbench

Multi-cycle multiply/divide unit. It sits between the 8-entry, 32-bit register file's read ports and its write port. It consumes two read operands and, after a fixed iteration count, produces a one-cycle register write request (data plus destination index). Shift-add and restoring-divide datapaths are shared behind one FSM.

---
 rtl/mdu_iterative_if.sv | 31 +++
 rtl/mdu_iterative.sv | 161 ++++++++++++++++
 tb/tb_mdu_iterative.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iterative_if.sv
// Bundle of request and register-write signals between the register file
// read/write ports and the iterative multiply/divide unit.
//   master: drives start/op/src_a/src_b/dest_reg, observes results
//   slave : the MDU itself
interface mdu_iterative_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 3
);
  logic                  start;
  logic [1:0]            op;
  logic [WIDTH-1:0]      src_a;
  logic [WIDTH-1:0]      src_b;
  logic [REG_ADDR_W-1:0] dest_reg;
  logic                  busy;
  logic                  done;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [WIDTH-1:0]      write_data;
  logic [WIDTH-1:0]      result_hi;
  logic                  div_by_zero;

  modport master (
    output start, op, src_a, src_b, dest_reg,
    input  busy, done, reg_write, write_reg, write_data, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, src_a, src_b, dest_reg,
    output busy, done, reg_write, write_reg, write_data, result_hi, div_by_zero
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide
// share one hi/lo datapath, one bit per cycle, WIDTH iterations.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mdu_iterative_if (request in, register write out)
// op: 00 MULU, 01 MUL, 10 DIVU, 11 DIV. Results: write_data = low/quotient,
// result_hi = high/remainder, div_by_zero flags a zero divisor.
module mdu_iterative #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 3
) (
  input logic            clk,
  input logic            rst_n,
  mdu_iterative_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  is_div_q, is_div_d;
  logic                  neg_q, neg_d;          // negate product / quotient
  logic                  rem_neg_q, rem_neg_d;  // negate remainder
  logic [WIDTH-1:0]      opnd_q, opnd_d;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0]      hi_q, hi_d;
  logic [WIDTH-1:0]      lo_q, lo_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [WIDTH-1:0]      write_data_q, write_data_d;
  logic [WIDTH-1:0]      result_hi_q, result_hi_d;
  logic                  dbz_q, dbz_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem_sh, div_trial;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;

  assign mag_a = (bus.op[0] && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign mag_b = (bus.op[0] && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

  // Multiply step: conditionally add multiplicand to hi, then shift {carry,hi,lo} right.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

  // Divide step: shift {rem,quo} left, keep trial subtraction if it did not borrow.
  assign div_rem_sh = {hi_q, lo_q[WIDTH-1]};
  assign div_trial  = div_rem_sh - {1'b0, opnd_q};

  always_comb begin
    if (is_div_q) begin
      step_hi = div_trial[WIDTH] ? div_rem_sh[WIDTH-1:0] : div_trial[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    prod = {step_hi, step_lo};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_div_d     = is_div_q;
    neg_d        = neg_q;
    rem_neg_d    = rem_neg_q;
    opnd_d       = opnd_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    dest_d       = dest_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    result_hi_d  = result_hi_q;
    dbz_d        = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          is_div_d  = bus.op[1];
          neg_d     = bus.op[0] & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
          rem_neg_d = bus.op[0] & bus.src_a[WIDTH-1];
          dest_d    = bus.dest_reg;
          cnt_d     = '0;
          hi_d      = '0;
          dbz_d     = 1'b0;
          if (bus.op[1] && (bus.src_b == '0)) begin
            // Zero divisor: skip the iterations, report dividend untouched.
            dbz_d        = 1'b1;
            write_data_d = '1;
            result_hi_d  = bus.src_a;
            write_reg_d  = bus.dest_reg;
            state_d      = StDone;
          end else begin
            opnd_d  = bus.op[1] ? mag_b : mag_a;
            lo_d    = bus.op[1] ? mag_a : mag_b;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          if (is_div_q) begin
            write_data_d = neg_q ? -step_lo : step_lo;
            result_hi_d  = rem_neg_q ? -step_hi : step_hi;
          end else begin
            {result_hi_d, write_data_d} = neg_q ? -prod : prod;
          end
          write_reg_d = dest_q;
          state_d     = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      is_div_q     <= 1'b0;
      neg_q        <= 1'b0;
      rem_neg_q    <= 1'b0;
      opnd_q       <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      dest_q       <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      result_hi_q  <= '0;
      dbz_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_div_q     <= is_div_d;
      neg_q        <= neg_d;
      rem_neg_q    <= rem_neg_d;
      opnd_q       <= opnd_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      dest_q       <= dest_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      result_hi_q  <= result_hi_d;
      dbz_q        <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.reg_write   = (state_q == StDone);
  assign bus.write_reg   = write_reg_q;
  assign bus.write_data  = write_data_q;
  assign bus.result_hi   = result_hi_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_iterative.sv
module tb_mdu_iterative;

  typedef struct packed {
    logic [31:0] wd;
    logic [31:0] rh;
    logic [2:0]  wr;
    logic        dbz;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   done_cnt;
  exp_t sb[$];
  exp_t mon_e;

  mdu_iterative_if #(.WIDTH(32), .REG_ADDR_W(3)) bus ();

  mdu_iterative #(.WIDTH(32), .REG_ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] wd, input logic [31:0] rh,
                              input logic [2:0] wr, input logic dbz);
    exp_t e;
    e.wd = wd; e.rh = rh; e.wr = wr; e.dbz = dbz;
    return e;
  endfunction

  // Reference model built on native 64-bit arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] d);
    exp_t e;
    logic [63:0] p;
    longint sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.wr = d; e.dbz = 1'b0;
    case (op)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; e.wd = p[31:0]; e.rh = p[63:32]; end
      2'b01: begin p = 64'(sa * sbv); e.wd = p[31:0]; e.rh = p[63:32]; end
      default: begin
        if (b == 32'd0) begin
          e.wd = '1; e.rh = a; e.dbz = 1'b1;
        end else if (op == 2'b10) begin
          e.wd = a / b; e.rh = a % b;
        end else begin
          q = sa / sbv; r = sa % sbv;
          e.wd = 32'(q); e.rh = 32'(r);
        end
      end
    endcase
    return e;
  endfunction

  // Scoreboard: every completion is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: write_data=%h with no request pending", bus.write_data);
      end else begin
        mon_e = sb.pop_front();
        if ({bus.write_data, bus.result_hi, bus.write_reg, bus.div_by_zero, bus.reg_write}
            !== {mon_e.wd, mon_e.rh, mon_e.wr, mon_e.dbz, 1'b1}) begin
          errors++;
          $display("FAIL result: got wd=%h rh=%h wr=%0d dbz=%b rw=%b, want wd=%h rh=%h wr=%0d dbz=%b rw=1",
                   bus.write_data, bus.result_hi, bus.write_reg, bus.div_by_zero,
                   bus.reg_write, mon_e.wd, mon_e.rh, mon_e.wr, mon_e.dbz);
        end
      end
    end
  end

  // Drive a request now, push its expectation, and confirm acceptance.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] d, input exp_t e);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.dest_reg = d;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL accept: busy=%b after start, want 1", bus.busy);
    end
  endtask

  // Count edges after the accept edge until done; then check one-cycle pulse.
  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.done !== 1'b1 || n != exp_lat) begin
      errors++;
      $display("FAIL latency: done=%b after %0d edges, want done=1 after %0d",
               bus.done, n, exp_lat);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL pulse: done=%b busy=%b cycle after done, want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.busy, bus.done, bus.reg_write, bus.div_by_zero, bus.write_reg,
         bus.write_data, bus.result_hi} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b wd=%h rh=%h wr=%0d, want all 0",
               bus.busy, bus.done, bus.write_data, bus.result_hi, bus.write_reg);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    issue(2'b00, 32'h0000FFFF, 32'h00010001, 3'd3, mk(32'hFFFFFFFF, 32'h0, 3'd3, 1'b0));
    wait_done(32);
    issue(2'b01, 32'hFFFFFFFD, 32'd7, 3'd0, mk(32'hFFFFFFEB, 32'hFFFFFFFF, 3'd0, 1'b0));
    wait_done(32);
    issue(2'b01, 32'h80000000, 32'h80000000, 3'd5, mk(32'h0, 32'h40000000, 3'd5, 1'b0));
    wait_done(32);
  endtask

  task automatic test_div();
    issue(2'b10, 32'd100, 32'd7, 3'd1, mk(32'h0000000E, 32'h00000002, 3'd1, 1'b0));
    wait_done(32);
    issue(2'b11, 32'hFFFFFFF9, 32'd2, 3'd2, mk(32'hFFFFFFFD, 32'hFFFFFFFF, 3'd2, 1'b0));
    wait_done(32);
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 3'd7, mk(32'h80000000, 32'h0, 3'd7, 1'b0));
    wait_done(32);
    issue(2'b11, 32'd7, 32'hFFFFFFFE, 3'd4, mk(32'hFFFFFFFD, 32'd1, 3'd4, 1'b0));
    wait_done(32);
  endtask

  task automatic test_div_by_zero();
    issue(2'b10, 32'd5, 32'd0, 3'd6, mk(32'hFFFFFFFF, 32'd5, 3'd6, 1'b1));
    wait_done(0);
    checks++;
    if (bus.div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_hold: div_by_zero=%b in idle, want 1", bus.div_by_zero);
    end
    issue(2'b00, 32'd2, 32'd3, 3'd6, mk(32'd6, 32'd0, 3'd6, 1'b0));
    checks++;
    if (bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL dbz_clear: div_by_zero=%b after accept, want 0", bus.div_by_zero);
    end
    wait_done(32);
    issue(2'b11, 32'hFFFFFFF0, 32'd0, 3'd0, mk(32'hFFFFFFFF, 32'hFFFFFFF0, 3'd0, 1'b1));
    wait_done(0);
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    issue(2'b00, 32'd2, 32'd3, 3'd2, mk(32'd6, 32'd0, 3'd2, 1'b0));
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'b10; bus.src_a = 32'd9; bus.src_b = 32'd3; bus.dest_reg = 3'd5;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b0; bus.src_a = 32'hDEADBEEF; bus.src_b = 32'h12345678;
    wait_done(32 - 7);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL ignored_start: %0d done pulses, want 1", done_cnt - d0);
    end
    // Back-to-back: accept in the first idle cycle after a completion.
    issue(2'b00, 32'd11, 32'd13, 3'd1, mk(32'd143, 32'd0, 3'd1, 1'b0));
    wait_done(32);
    issue(2'b10, 32'd9, 32'd3, 3'd3, mk(32'd3, 32'd0, 3'd3, 1'b0));
    wait_done(32);
  endtask

  task automatic test_reset_mid_op();
    int d0;
    issue(2'b01, 32'hFFFFFF00, 32'd77, 3'd4, model(2'b01, 32'hFFFFFF00, 32'd77, 3'd4));
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.reg_write, bus.div_by_zero, bus.write_reg,
         bus.write_data, bus.result_hi} !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b wd=%h rh=%h wr=%0d, want all 0",
               bus.busy, bus.write_data, bus.result_hi, bus.write_reg);
    end
    sb.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL no_done_after_reset: %0d done pulses, want 0", done_cnt - d0);
    end
    issue(2'b00, 32'd4, 32'd5, 3'd2, mk(32'd20, 32'd0, 3'd2, 1'b0));
    wait_done(32);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [2:0]  d;
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(3, 0));
      a  = $urandom;
      b  = (i % 4 == 3) ? 32'($urandom_range(15, 0)) : $urandom;
      if (i == 5) b = 32'd0;
      d  = 3'($urandom_range(7, 0));
      issue(op, a, b, d, model(op, a, b, d));
      wait_done((op[1] && b == 32'd0) ? 0 : 32);
    end
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0;
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0; bus.dest_reg = '0;
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
